sram_req_ctrl: RTL and testbench
================================

Name: sram_req_ctrl

Overview:
- Upstream controller for the single-port SRAM (ports DataIn, DataOut, Addr, CS, WE, RD, Clk).
- Converts a valid/ready request stream (read or write) into correctly timed SRAM strobes.
- Returns read data on a valid/ready response channel.
- After reset, zero-fills the whole array before it accepts any traffic.

Parameters:
ADR, 8, address width (matches SRAM ADR)
DATA, 8, data width (matches SRAM Data)
DEPTH, 256, number of implemented words; legal addresses 0..DEPTH-1
INIT_EN, 1, 1 = zero-fill after reset; 0 = go straight to IDLE

Ports:
Clk  in  1  system clock, rising edge
Rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_we  in  1  1 = write, 0 = read
req_addr  in  ADR  request address
req_wdata  in  DATA  write data
rsp_valid  out  1  read response present
rsp_ready  in  1  consumer takes response
rsp_rdata  out  DATA  read data
rsp_err  out  1  request address >= DEPTH
init_done  out  1  zero-fill complete
CS  out  1  SRAM chip select
WE  out  1  SRAM write enable
RD  out  1  SRAM read enable
Addr  out  ADR  SRAM address
DataIn  out  DATA  SRAM write data
DataOut  in  DATA  SRAM read data

Behaviour:
- SRAM contract:
  - Write occurs on the rising edge where CS=1 and WE=1.
  - DataOut is registered on the edge where CS=1 and RD=1, and is valid the following cycle.
- All SRAM-side outputs are registered.
- Reset (Rst_n=0, asynchronous):
  - CS, WE, RD, Addr, DataIn = 0; req_ready = 0; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0; init_done = 0.
  - FSM = INIT if INIT_EN, else IDLE.
  - Reset asserted mid-operation aborts everything; the next fill restarts at address 0.
- States: INIT, IDLE, WRITE, READ, CAPTURE, RSP.
- INIT:
  - Drives CS=1, WE=1, DataIn=0, Addr=counter; counter runs 0..DEPTH-1, one word per cycle.
  - After the DEPTH-1 write, go to IDLE and set init_done=1 (sticky until reset).
  - req_ready=0 throughout; fill takes exactly DEPTH cycles.
- IDLE:
  - req_ready=1; CS=WE=RD=0.
  - Handshake occurs when req_valid & req_ready on a rising edge; request fields are captured at that edge.
- Address check:
  - req_addr >= DEPTH with req_we=1: go to IDLE with no SRAM access (write dropped).
  - req_addr >= DEPTH with req_we=0: go directly to RSP with rsp_rdata=0, rsp_err=1.
- WRITE (one cycle): CS=1, WE=1, Addr/DataIn = captured values; next state IDLE.
  - Write throughput is one write per 2 cycles.
- READ (one cycle): CS=1, RD=1, Addr = captured address; next state CAPTURE.
- CAPTURE: CS=RD=0; rsp_rdata <= DataOut, rsp_err <= 0 at the cycle end; next state RSP.
- RSP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable while rsp_ready=0; req_ready=0.
  - On rsp_valid & rsp_ready: rsp_valid clears next cycle and the FSM goes to IDLE.
- Read latency: request accepted at edge N gives rsp_valid high in cycle N+3 (legal address).
- Back-to-back: a new request is accepted no earlier than the cycle after the response handshake.
- Strobes: WE and RD are never both 1; CS=0 whenever WE=RD=0.
- req_valid held high while req_ready=0 has no effect; fields must stay stable (consumer rule).

Decomposition:
- Package sram_req_ctrl_pkg:
  - State enum (INIT, IDLE, WRITE, READ, CAPTURE, RSP).
  - Localparams OP_RD=0 and OP_WR=1.
- Single module, no sub-module; the INIT sweep is a counter inside the FSM, not worth a separate block.

Test Plan:
- Reset then run with INIT_EN=1, DEPTH=256 -> init_done rises exactly 256 cycles after Rst_n release; each cycle shows CS=1, WE=1, DataIn=0 with Addr 0..255; req_ready=0 until then.
- Writes 0x10->@0x10, 0x20->@0x20, 0x30->@0x30, 0x40->@0x40, then reads of the same addresses (rsp_ready=1) -> rsp_rdata 0x10, 0x20, 0x30, 0x40 in order, each 3 cycles after accept, rsp_err=0.
- Read @0x55 never written -> rsp_rdata=0x00 (from the fill), rsp_err=0.
- Read @0x10 with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata=0x10 stable, req_ready=0; release -> IDLE next cycle.
- DEPTH=200: write 0xAA @0xF0 then read @0xF0 -> no SRAM strobe for either; response rsp_err=1, rsp_rdata=0.
- Rst_n pulsed low during INIT at Addr=0x80 -> outputs clear immediately; after release the fill restarts at Addr=0 and runs the full 256 cycles.

Source files
------------

// File: rtl/sram_req_ctrl_pkg.sv
// rtl/sram_req_ctrl_pkg.sv - state encoding and opcode constants for sram_req_ctrl
package sram_req_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_CAPTURE,
    ST_RSP
  } state_t;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/sram_req_ctrl.sv
// rtl/sram_req_ctrl.sv - request/response front end for a single-port SRAM
// All SRAM strobes and handshake outputs are registered from the next-state logic.
module sram_req_ctrl
  import sram_req_ctrl_pkg::*;
#(
  parameter int ADR     = 8,
  parameter int DATA    = 8,
  parameter int DEPTH   = 256,
  parameter bit INIT_EN = 1'b1
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [ADR-1:0]  req_addr,
  input  logic [DATA-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DATA-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            init_done,
  output logic            CS,
  output logic            WE,
  output logic            RD,
  output logic [ADR-1:0]  Addr,
  output logic [DATA-1:0] DataIn,
  input  logic [DATA-1:0] DataOut
);

  localparam logic [ADR-1:0] LAST = ADR'(DEPTH - 1);

  state_t          state, state_d;
  logic [ADR-1:0]  cnt, cnt_d;
  logic            cs_d, we_d, rd_d, rdy_d, vld_d, err_d, done_d;
  logic [ADR-1:0]  addr_d;
  logic [DATA-1:0] din_d, rdata_d;
  logic            hs, oor;

  assign hs  = req_valid & req_ready;
  assign oor = {{(32-ADR){1'b0}}, req_addr} >= 32'(DEPTH);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    cs_d    = 1'b0;
    we_d    = 1'b0;
    rd_d    = 1'b0;
    addr_d  = Addr;
    din_d   = DataIn;
    rdy_d   = 1'b0;
    vld_d   = rsp_valid;
    rdata_d = rsp_rdata;
    err_d   = rsp_err;
    done_d  = init_done;
    case (state)
      ST_INIT: begin
        // The last fill word is still on the bus during the first IDLE cycle;
        // a request accepted then reaches the SRAM one edge later.
        cs_d   = 1'b1;
        we_d   = 1'b1;
        addr_d = cnt;
        din_d  = '0;
        cnt_d  = cnt + 1'b1;
        if (cnt == LAST) begin
          state_d = ST_IDLE;
          rdy_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      ST_IDLE: begin
        rdy_d  = 1'b1;
        done_d = 1'b1;
        if (hs) begin
          if (req_we == OP_WR) begin
            if (!oor) begin
              state_d = ST_WRITE;
              cs_d    = 1'b1;
              we_d    = 1'b1;
              addr_d  = req_addr;
              din_d   = req_wdata;
              rdy_d   = 1'b0;
            end
          end else if (oor) begin
            state_d = ST_RSP;
            vld_d   = 1'b1;
            rdata_d = '0;
            err_d   = 1'b1;
            rdy_d   = 1'b0;
          end else begin
            state_d = ST_READ;
            cs_d    = 1'b1;
            rd_d    = 1'b1;
            addr_d  = req_addr;
            rdy_d   = 1'b0;
          end
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
        rdy_d   = 1'b1;
      end
      ST_READ: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        rdata_d = DataOut;
        err_d   = 1'b0;
        vld_d   = 1'b1;
        state_d = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_valid && rsp_ready) begin
          vld_d   = 1'b0;
          state_d = ST_IDLE;
          rdy_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= INIT_EN ? ST_INIT : ST_IDLE;
      cnt       <= '0;
      CS        <= 1'b0;
      WE        <= 1'b0;
      RD        <= 1'b0;
      Addr      <= '0;
      DataIn    <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      CS        <= cs_d;
      WE        <= we_d;
      RD        <= rd_d;
      Addr      <= addr_d;
      DataIn    <= din_d;
      req_ready <= rdy_d;
      rsp_valid <= vld_d;
      rsp_rdata <= rdata_d;
      rsp_err   <= err_d;
      init_done <= done_d;
    end
  end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb/tb_sram_req_ctrl.sv - directed bench for sram_req_ctrl with a behavioural SRAM
module tb_sram_req_ctrl;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       req_valid, req_we, rsp_ready;
  logic [7:0] req_addr, req_wdata;
  logic       req_ready, rsp_valid, rsp_err, init_done, CS, WE, RD;
  logic [7:0] rsp_rdata, Addr, DataIn, DataOut;

  logic       b_req_valid, b_req_we, b_rsp_ready;
  logic [7:0] b_req_addr, b_req_wdata;
  logic       b_req_ready, b_rsp_valid, b_rsp_err, b_init_done, b_CS, b_WE, b_RD;
  logic [7:0] b_rsp_rdata, b_Addr, b_DataIn, b_DataOut;

  logic [7:0] mem [256] = '{default: 8'hFF};
  int total = 0;
  int bad = 0;

  assign b_DataOut = 8'hEE;

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (CS && WE) mem[Addr] <= DataIn;
    if (CS && RD) DataOut <= mem[Addr];
  end

  sram_req_ctrl #(.ADR(8), .DATA(8), .DEPTH(256), .INIT_EN(1'b1)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .init_done(init_done),
    .CS(CS), .WE(WE), .RD(RD), .Addr(Addr), .DataIn(DataIn), .DataOut(DataOut)
  );

  sram_req_ctrl #(.ADR(8), .DATA(8), .DEPTH(200), .INIT_EN(1'b0)) dut2 (
    .Clk(Clk), .Rst_n(Rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .init_done(b_init_done),
    .CS(b_CS), .WE(b_WE), .RD(b_RD), .Addr(b_Addr), .DataIn(b_DataIn), .DataOut(b_DataOut)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge Clk);
      check("fill_bus", {CS, WE, RD, Addr, DataIn}, {3'b110, 8'(k - 1), 8'h00});
      check("fill_flags", {req_ready, init_done}, (k == 256) ? 2'b11 : 2'b00);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    check("wr_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    @(negedge Clk);
    check("wr_bus", {CS, WE, RD, Addr, DataIn, req_ready}, {3'b110, a, d, 1'b0});
    req_valid = 1'b0;
    @(negedge Clk);
    check("wr_done", {CS, WE, RD, req_ready}, 4'b0001);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input logic stall);
    check("rd_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    @(negedge Clk);
    check("rd_bus", {CS, WE, RD, Addr, req_ready}, {3'b101, a, 1'b0});
    req_valid = 1'b0;
    rsp_ready = !stall;
    @(negedge Clk);
    check("rd_capture", {CS, WE, RD, rsp_valid}, 4'b0000);
    @(negedge Clk);
    check("rd_rsp", {rsp_valid, rsp_err, rsp_rdata, req_ready}, {2'b10, exp, 1'b0});
    if (stall) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge Clk);
        check("rd_hold", {rsp_valid, rsp_err, rsp_rdata, req_ready, CS}, {2'b10, exp, 2'b00});
      end
      rsp_ready = 1'b1;
    end
    @(negedge Clk);
    check("rd_release", {rsp_valid, req_ready}, 2'b01);
  endtask

  task automatic b_wr(input logic [7:0] a, input logic [7:0] d);
    check("b_wr_ready", b_req_ready, 1'b1);
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = a; b_req_wdata = d;
    @(negedge Clk);
    check("b_wr_drop", {b_CS, b_WE, b_RD, b_req_ready}, 4'b0001);
    b_req_valid = 1'b0;
  endtask

  task automatic b_rd(input logic [7:0] a, input logic legal, input logic [7:0] exp);
    check("b_rd_ready", b_req_ready, 1'b1);
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = a;
    @(negedge Clk);
    b_req_valid = 1'b0;
    if (legal) begin
      check("b_rd_bus", {b_CS, b_WE, b_RD, b_Addr}, {3'b101, a});
      @(negedge Clk);
      @(negedge Clk);
    end else begin
      check("b_rd_nobus", {b_CS, b_WE, b_RD}, 3'b000);
    end
    check("b_rd_rsp", {b_rsp_valid, b_rsp_err, b_rsp_rdata}, {1'b1, !legal, exp});
    @(negedge Clk);
    check("b_rd_release", {b_rsp_valid, b_req_ready, b_CS}, 3'b010);
  endtask

  initial begin
    Rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1'b1;
    repeat (2) @(negedge Clk);
    check("reset", {CS, WE, RD, Addr, DataIn, req_ready, rsp_valid, rsp_rdata, rsp_err, init_done}, 0);

    Rst_n = 1'b1;
    fill(129);
    Rst_n = 1'b0;
    #1;
    check("abort", {CS, WE, RD, Addr, DataIn, req_ready, rsp_valid, rsp_rdata, rsp_err, init_done}, 0);
    @(negedge Clk);
    check("abort_hold", {CS, WE, RD, Addr, DataIn, req_ready, init_done}, 0);
    Rst_n = 1'b1;
    fill(256);
    @(negedge Clk);
    check("idle", {CS, WE, RD, req_ready, init_done}, 5'b00011);

    wr(8'h10, 8'h10);
    wr(8'h20, 8'h20);
    wr(8'h30, 8'h30);
    wr(8'h40, 8'h40);
    rd(8'h10, 8'h10, 1'b0);
    rd(8'h20, 8'h20, 1'b0);
    rd(8'h30, 8'h30, 1'b0);
    rd(8'h40, 8'h40, 1'b0);
    rd(8'h55, 8'h00, 1'b0);
    rd(8'hC3, 8'h00, 1'b0);
    rd(8'h10, 8'h10, 1'b1);

    b_wr(8'hF0, 8'hAA);
    b_rd(8'hF0, 1'b0, 8'h00);
    b_rd(8'hC7, 1'b1, 8'hEE);
    b_rd(8'hC8, 1'b0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
